// File: rtl/ufm_imageload_pkg.sv
// ---------------------------------------------------------------------------
// ufm_imageload_pkg
//  Shared definitions for the UFM boot-image loader:
//   - loader FSM state encoding (3-bit)
//   - default header magic value
//   - header field positions and small field-extraction helpers
// ---------------------------------------------------------------------------
package ufm_imageload_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdrRd = 3'd1,
        StHdrWt = 3'd2,
        StDatRd = 3'd3,
        StDatWt = 3'd4,
        StSumRd = 3'd5,
        StSumWt = 3'd6,
        StDone  = 3'd7
    } state_e;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hCE5A;

    // Header word layout: {magic, payload word count}
    localparam int unsigned HDR_MAGIC_MSB = 31;
    localparam int unsigned HDR_MAGIC_LSB = 16;
    localparam int unsigned HDR_COUNT_MSB = 15;
    localparam int unsigned HDR_COUNT_LSB = 0;

    function automatic logic [15:0] hdr_magic(input logic [31:0] hdr);
        return hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    endfunction

    function automatic logic [15:0] hdr_count(input logic [31:0] hdr);
        return hdr[HDR_COUNT_MSB:HDR_COUNT_LSB];
    endfunction

endpackage

// File: rtl/ufm_rdport.sv
// ---------------------------------------------------------------------------
// ufm_rdport
//  Single-outstanding Avalon-MM read engine for the UFM data port.
//  A one-cycle start loads the request address and raises read; read and
//  address are held until waitrequest drops. On acceptance read falls, the
//  address advances by one word and the engine waits for readdatavalid.
//  readdatavalid is only honoured while a read is outstanding.
//
// Ports
//  clk, rst            clock, synchronous active-high reset
//  start               issue a read at addr (only when idle)
//  addr                word address for the read being started
//  accept              read accepted this cycle (read & !waitrequest)
//  rdata, rvalid       returned word and its qualifier
//  avm_address         Avalon address (resets to BASE_ADDR)
//  avm_read            Avalon read request
//  avm_waitrequest     Avalon waitrequest
//  avm_readdata        Avalon readdata
//  avm_readdatavalid   Avalon readdatavalid
// ---------------------------------------------------------------------------
module ufm_rdport #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  accept,
    output logic [31:0]           rdata,
    output logic                  rvalid,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid
);

    logic                  pending_q, pending_d;
    logic                  outstanding_q, outstanding_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign accept      = pending_q & ~avm_waitrequest;
    assign rvalid      = outstanding_q & avm_readdatavalid;
    assign rdata       = avm_readdata;
    assign avm_read    = pending_q;
    assign avm_address = addr_q;

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        addr_d        = addr_q;
        if (start) begin
            pending_d = 1'b1;
            addr_d    = addr;
        end
        if (accept) begin
            pending_d     = 1'b0;
            outstanding_d = 1'b1;
            addr_d        = addr_q + ADDR_WIDTH'(1);
        end
        if (rvalid) begin
            outstanding_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= 1'b0;
            outstanding_q <= 1'b0;
            addr_q        <= ADDR_WIDTH'(BASE_ADDR);
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            addr_q        <= addr_d;
        end
    end

endmodule

// File: rtl/ufm_imageload.sv
// ---------------------------------------------------------------------------
// ufm_imageload
//  Boot-image loader: after reset reads {MAGIC, N} header, N payload words
//  and a 32-bit additive checksum from on-chip user flash, streaming the
//  payload to the init-memory stage as one-cycle write pulses.
//
// Ports
//  csi_s1_clock          clock
//  rsi_s1_reset          synchronous active-high reset (aborts any load)
//  avm_m1_*              Avalon-MM read master towards the UFM data port
//  coe_data              payload word (holds last value)
//  coe_datavalid         one-cycle pulse per payload word
//  coe_initdone          load finished, sticky until reset
//  coe_initerror         bad header or checksum, sticky until reset
// ---------------------------------------------------------------------------
module ufm_imageload
    import ufm_imageload_pkg::*;
#(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter logic [15:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic                  csi_s1_clock,
    input  logic                  rsi_s1_reset,
    output logic [ADDR_WIDTH-1:0] avm_m1_address,
    output logic                  avm_m1_read,
    input  logic                  avm_m1_waitrequest,
    input  logic [31:0]           avm_m1_readdata,
    input  logic                  avm_m1_readdatavalid,
    output logic [31:0]           coe_data,
    output logic                  coe_datavalid,
    output logic                  coe_initdone,
    output logic                  coe_initerror
);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] data_q, data_d;
    logic        datavalid_q, datavalid_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        rd_start;
    logic        rd_accept;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        hdr_bad;

    // Image words are contiguous, so each new read starts where the read
    // engine's post-increment address already points.
    ufm_rdport #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_rdport (
        .clk               (csi_s1_clock),
        .rst               (rsi_s1_reset),
        .start             (rd_start),
        .addr              (avm_m1_address),
        .accept            (rd_accept),
        .rdata             (rd_data),
        .rvalid            (rd_valid),
        .avm_address       (avm_m1_address),
        .avm_read          (avm_m1_read),
        .avm_waitrequest   (avm_m1_waitrequest),
        .avm_readdata      (avm_m1_readdata),
        .avm_readdatavalid (avm_m1_readdatavalid)
    );

    assign hdr_bad = (hdr_magic(rd_data) != MAGIC) ||
                     ({16'd0, hdr_count(rd_data)} > 32'(MAX_WORDS));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        data_d      = data_q;
        datavalid_d = 1'b0;
        done_d      = done_q;
        error_d     = error_q;
        rd_start    = 1'b0;

        unique case (state_q)
            StIdle: begin
                rd_start = 1'b1;
                state_d  = StHdrRd;
            end
            StHdrRd: begin
                if (rd_accept) state_d = StHdrWt;
            end
            StHdrWt: begin
                if (rd_valid) begin
                    if (hdr_bad) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (hdr_count(rd_data) == 16'd0) begin
                        rd_start = 1'b1;
                        state_d  = StSumRd;
                    end else begin
                        count_d  = hdr_count(rd_data);
                        rd_start = 1'b1;
                        state_d  = StDatRd;
                    end
                end
            end
            StDatRd: begin
                if (rd_accept) state_d = StDatWt;
            end
            StDatWt: begin
                if (rd_valid) begin
                    data_d      = rd_data;
                    datavalid_d = 1'b1;
                    acc_d       = acc_q + rd_data;
                    count_d     = count_q - 16'd1;
                    rd_start    = 1'b1;
                    state_d     = (count_q == 16'd1) ? StSumRd : StDatRd;
                end
            end
            StSumRd: begin
                if (rd_accept) state_d = StSumWt;
            end
            StSumWt: begin
                if (rd_valid) begin
                    if (rd_data != acc_q) error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge csi_s1_clock) begin
        if (rsi_s1_reset) begin
            state_q     <= StIdle;
            count_q     <= 16'd0;
            acc_q       <= 32'd0;
            data_q      <= 32'd0;
            datavalid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            datavalid_q <= datavalid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign coe_data      = data_q;
    assign coe_datavalid = datavalid_q;
    assign coe_initdone  = done_q;
    assign coe_initerror = error_q;

endmodule
